loadable_down_timer: RTL and testbench

//  Loadable down-counter/timer: holds a WIDTH-bit count register and steps it

---
 rtl/loadable_down_timer.sv | 90 +++++++++
 tb/tb_loadable_down_timer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/loadable_down_timer.sv
// Loadable down-counter with an IDLE/RUN/DONE controller and a one-cycle done pulse.
// Optional auto-reload restarts from the last loaded value after every terminal count.
module loadable_down_timer #(
  parameter int WIDTH       = 4,
  parameter int AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_r;
  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] dec_s;

  // Decrement datapath; RUN never holds zero, so the modulo wrap is never consumed
  assign dec_s = count_r - ONE;

  // Controller and count/reload registers: clr beats load, load beats counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      count_r  <= ZERO;
      reload_r <= ZERO;
    end else if (clr) begin
      state_r <= IDLE;
      count_r <= ZERO;
    end else if (load) begin
      reload_r <= load_val;
      if (load_val != ZERO) begin
        count_r <= load_val;
        state_r <= RUN;
      end else begin
        count_r <= ZERO;
        state_r <= DONE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r <= IDLE;
        end
        RUN: begin
          if (en) begin
            if (count_r == ONE) begin
              count_r <= ZERO;
              state_r <= DONE;
            end else begin
              count_r <= dec_s;
            end
          end
        end
        DONE: begin
          // A zero reload value keeps the timer in DONE, pulsing every cycle
          if (AUTO_RELOAD != 0) begin
            count_r <= reload_r;
            state_r <= (reload_r != ZERO) ? RUN : DONE;
          end else begin
            count_r <= ZERO;
            state_r <= IDLE;
          end
        end
        default: begin
          count_r <= ZERO;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign count = count_r;
  assign busy  = (state_r == RUN);
  assign done  = (state_r == DONE);

endmodule

// File: tb/tb_loadable_down_timer.sv
// Directed bench: one instance without and one with auto-reload, driven from shared inputs.
module tb_loadable_down_timer;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] load_val;
  logic       en;
  logic       clr;
  logic [3:0] count_a, count_b;
  logic       busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  loadable_down_timer #(.WIDTH(4), .AUTO_RELOAD(0)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en), .clr(clr),
    .count(count_a), .busy(busy_a), .done(done_a)
  );

  loadable_down_timer #(.WIDTH(4), .AUTO_RELOAD(1)) dut_ar (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val), .en(en), .clr(clr),
    .count(count_b), .busy(busy_b), .done(done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic exp_a(input string tag, input int c, input int b, input int d);
    chk({tag, ".count"}, int'(count_a), c);
    chk({tag, ".busy"}, int'(busy_a), b);
    chk({tag, ".done"}, int'(done_a), d);
  endtask

  task automatic exp_b(input string tag, input int c, input int b, input int d);
    chk({tag, ".count"}, int'(count_b), c);
    chk({tag, ".busy"}, int'(busy_b), b);
    chk({tag, ".done"}, int'(done_b), d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; clr = 1'b0;
    #12;
    exp_a("reset", 0, 0, 0);
    exp_b("reset_ar", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load 5 with steady enable: 5,4,3,2,1 busy, then 0 with done, then idle
    load = 1'b1; load_val = 4'd5; en = 1'b1;
    step();
    load = 1'b0;
    exp_a("l5_c5", 5, 1, 0);
    for (int v = 4; v >= 1; v--) begin
      step();
      exp_a($sformatf("l5_c%0d", v), v, 1, 0);
    end
    step();
    exp_a("l5_done", 0, 0, 1);
    step();
    exp_a("l5_idle", 0, 0, 0);
    step();
    exp_a("l5_idle2", 0, 0, 0);

    // Enable pattern 1,0,0,1,1 after loading 3
    load = 1'b1; load_val = 4'd3; en = 1'b1;
    step();
    load = 1'b0;
    exp_a("l3_c3", 3, 1, 0);
    en = 1'b1; step(); exp_a("l3_e1", 2, 1, 0);
    en = 1'b0; step(); exp_a("l3_e0a", 2, 1, 0);
    en = 1'b0; step(); exp_a("l3_e0b", 2, 1, 0);
    en = 1'b1; step(); exp_a("l3_e1b", 1, 1, 0);
    en = 1'b1; step(); exp_a("l3_done", 0, 0, 1);
    step(); exp_a("l3_idle", 0, 0, 0);

    // Load 0 goes straight to a single done cycle, never busy
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    exp_a("l0_done", 0, 0, 1);
    step(); exp_a("l0_idle", 0, 0, 0);

    // Load 15, reload 4 at count 9: a single done at the end
    load = 1'b1; load_val = 4'd15; en = 1'b1;
    step();
    load = 1'b0;
    exp_a("l15_c15", 15, 1, 0);
    for (int v = 14; v >= 9; v--) begin
      step();
      exp_a($sformatf("l15_c%0d", v), v, 1, 0);
    end
    load = 1'b1; load_val = 4'd4;
    step();
    load = 1'b0;
    exp_a("rl4_c4", 4, 1, 0);
    for (int v = 3; v >= 1; v--) begin
      step();
      exp_a($sformatf("rl4_c%0d", v), v, 1, 0);
    end
    step(); exp_a("rl4_done", 0, 0, 1);
    step(); exp_a("rl4_idle", 0, 0, 0);

    // Full-range count from 15 to terminal count
    load = 1'b1; load_val = 4'd15;
    step();
    load = 1'b0;
    for (int v = 14; v >= 1; v--) step();
    exp_a("max_c1", 1, 1, 0);
    step(); exp_a("max_done", 0, 0, 1);
    step(); exp_a("max_idle", 0, 0, 0);

    // Clr and load together: clr wins; load and en: load wins (covered above)
    clr = 1'b1; load = 1'b1; load_val = 4'd6;
    step();
    clr = 1'b0; load = 1'b0;
    exp_a("clr_vs_load", 0, 0, 0);

    // Asynchronous reset mid-run at count 7
    load = 1'b1; load_val = 4'd10; en = 1'b1;
    step();
    load = 1'b0;
    step(); step(); step();
    exp_a("pre_rst_c7", 7, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    exp_a("async_rst", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(); exp_a("post_rst_idle", 0, 0, 0);

    // Auto-reload: load 2 gives 2,1,0,2,1,0 with done on each 0
    do_reset();
    load = 1'b1; load_val = 4'd2; en = 1'b1;
    step();
    load = 1'b0;
    exp_b("ar_c2a", 2, 1, 0);
    step(); exp_b("ar_c1a", 1, 1, 0);
    step(); exp_b("ar_done_a", 0, 0, 1);
    step(); exp_b("ar_c2b", 2, 1, 0);
    step(); exp_b("ar_c1b", 1, 1, 0);
    step(); exp_b("ar_done_b", 0, 0, 1);
    step(); exp_b("ar_c2c", 2, 1, 0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_b("ar_clr", 0, 0, 0);
    step(); exp_b("ar_clr_idle", 0, 0, 0);
    step(); exp_b("ar_clr_idle2", 0, 0, 0);

    // Auto-reload with zero: done held every cycle until cleared
    load = 1'b1; load_val = 4'd0;
    step();
    load = 1'b0;
    exp_b("ar0_done1", 0, 0, 1);
    step(); exp_b("ar0_done2", 0, 0, 1);
    step(); exp_b("ar0_done3", 0, 0, 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    exp_b("ar0_clr", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
